spi_bus_arbiter: RTL

- Shares the board's single SPI bus (SCK/MOSI/MISO plus chip selects: SD card, guest SS2, SS3, SS4, CONF_DATA0) between two byte-level requesters.
- Requester A is the controller's SD/config path. Requester B is the direct-upload path.
- Contains the mode-0 byte shift engine, clock divider, chip-select lock and round-robin grant.
- Sits between the controller core and the top-level SPI pins.

---
 rtl/spi_bus_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one mode-0 SPI bus between two byte
// requesters with round-robin grant and chip-select locking.
module spi_bus_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int N_CS    = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_req,
  input  logic            b_req,
  input  logic [2:0]      a_cs_sel,
  input  logic [2:0]      b_cs_sel,
  input  logic [7:0]      a_wdata,
  input  logic [7:0]      b_wdata,
  input  logic            a_hold,
  input  logic            b_hold,
  output logic            a_ack,
  output logic            b_ack,
  output logic [7:0]      rdata,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic [N_CS-1:0] cs_n,
  output logic            busy,
  output logic            owner
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] HLAST = CW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_OWNED = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   hcnt_q, hcnt_d;
  logic [4:0]      ecnt_q, ecnt_d;
  logic            sck_q, sck_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [N_CS-1:0] csn_q, csn_d;
  logic            hold_q, hold_d;
  logic            owner_q, owner_d;

  logic            hlast;
  logic            gnt_b;
  logic [2:0]      sel_cs;
  logic [7:0]      sel_wdata;
  logic            sel_hold;
  logic            own_req;
  logic [7:0]      own_wdata;
  logic            own_hold;
  logic [N_CS-1:0] csn_sel;

  assign hlast = (hcnt_q == HLAST);

  // Contention goes to whoever did not own the bus last.
  assign gnt_b     = b_req & (~a_req | ~owner_q);
  assign sel_cs    = gnt_b ? b_cs_sel : a_cs_sel;
  assign sel_wdata = gnt_b ? b_wdata  : a_wdata;
  assign sel_hold  = gnt_b ? b_hold   : a_hold;

  assign own_req   = owner_q ? b_req   : a_req;
  assign own_wdata = owner_q ? b_wdata : a_wdata;
  assign own_hold  = owner_q ? b_hold  : a_hold;

  always_comb begin
    csn_sel = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (32'(sel_cs) == i) csn_sel[i] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    ecnt_d  = ecnt_q;
    sck_d   = sck_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    csn_d   = csn_q;
    hold_d  = hold_q;
    owner_d = owner_q;
    unique case (state_q)
      S_IDLE: begin
        if (a_req | b_req) begin
          owner_d = gnt_b;
          tx_d    = sel_wdata;
          hold_d  = sel_hold;
          csn_d   = csn_sel;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (hlast) begin
          hcnt_d  = '0;
          state_d = S_SHIFT;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (hlast) begin
          hcnt_d = '0;
          ecnt_d = ecnt_q + 5'd1;
          sck_d  = ~sck_q;
          // Low SCK going high samples; high going low shifts out.
          if (!sck_q) rx_d = {rx_q[6:0], spi_miso};
          else        tx_d = {tx_q[6:0], 1'b1};
          if (ecnt_q == 5'd15) begin
            ecnt_d  = '0;
            sck_d   = 1'b0;
            rdata_d = rx_q;
            state_d = S_DONE;
          end
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (hold_q) begin
          state_d = S_OWNED;
        end else begin
          csn_d   = '1;
          tx_d    = '1;
          state_d = S_GAP;
        end
      end
      S_OWNED: begin
        if (own_req) begin
          tx_d    = own_wdata;
          hold_d  = own_hold;
          state_d = S_SHIFT;
        end
      end
      S_GAP: begin
        if (hlast) begin
          hcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      default: begin
        csn_d   = '1;
        tx_d    = '1;
        sck_d   = 1'b0;
        hcnt_d  = '0;
        ecnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      ecnt_q  <= '0;
      sck_q   <= 1'b0;
      tx_q    <= '1;
      rx_q    <= '0;
      rdata_q <= '0;
      csn_q   <= '1;
      hold_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      ecnt_q  <= ecnt_d;
      sck_q   <= sck_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      csn_q   <= csn_d;
      hold_q  <= hold_d;
      owner_q <= owner_d;
    end
  end

  assign a_ack    = (state_q == S_DONE) & ~owner_q;
  assign b_ack    = (state_q == S_DONE) &  owner_q;
  assign rdata    = rdata_q;
  assign spi_clk  = sck_q;
  assign spi_mosi = tx_q[7];
  assign cs_n     = csn_q;
  assign busy     = (state_q != S_IDLE);
  assign owner    = owner_q;

endmodule
